adc_spi_conf_engine: RTL

- Responder side of the ADC-configuration handshake: accepts `init_ADCconf` + `op_ADC` from the DCM/ADC sync sequencer and returns `end_ADCconf`.
- Translates each op into SPI register writes to the serial ADC (24-bit frame: 16-bit instruction + 8-bit data), each followed by a transfer-register commit.
- Also serves host (slow-control) register writes, and flags them to the sequencer on `ADC_confwt` so the two sources never interleave on the SPI bus.

---
 rtl/adc_conf_pkg.sv | 73 +++++++
 rtl/adc_spi_shifter.sv | 127 ++++++++++++
 rtl/adc_spi_conf_engine.sv | 138 +++++++++++++
 3 files changed

// File: rtl/adc_conf_pkg.sv
// rtl/adc_conf_pkg.sv - shared op codes, register map and state types for the ADC SPI config engine
package adc_conf_pkg;

  // Operation codes presented by the DCM/ADC sync sequencer on op_ADC
  localparam logic [2:0] OP_NONE = 3'b000;
  localparam logic [2:0] OP_FCO  = 3'b001;
  localparam logic [2:0] OP_DCO  = 3'b010;
  localparam logic [2:0] OP_RAMP = 3'b011;
  localparam logic [2:0] OP_END  = 3'b100;
  localparam logic [2:0] OP_NORM = 3'b101;
  localparam logic [2:0] OP_DEL  = 3'b110;

  // ADC register addresses
  localparam logic [12:0] REG_TESTIO = 13'h00D;
  localparam logic [12:0] REG_DELAY  = 13'h017;
  localparam logic [12:0] REG_XFER   = 13'h0FF;

  // Test-pattern register values and the transfer-register commit value
  localparam logic [7:0] TP_DCO      = 8'h09;
  localparam logic [7:0] TP_FCO      = 8'h0A;
  localparam logic [7:0] TP_RAMP     = 8'h0F;
  localparam logic [7:0] TP_NORM     = 8'h00;
  localparam logic [7:0] XFER_COMMIT = 8'h01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_GAP,
    ST_COMMIT_LOAD,
    ST_DONE
  } conf_state_e;

  typedef enum logic [2:0] {
    SH_IDLE,
    SH_LOW,
    SH_HIGH,
    SH_TAIL,
    SH_GAP
  } sh_phase_e;

  typedef struct packed {
    logic        traffic;
    logic [12:0] addr;
    logic [7:0]  data;
  } op_write_t;

  // Map a sequencer op to its single register write; ops without a write clear traffic
  function automatic op_write_t decode_op(input logic [2:0] op, input logic [7:0] delay_val);
    op_write_t w;
    w.traffic = 1'b1;
    w.addr    = REG_TESTIO;
    w.data    = TP_NORM;
    case (op)
      OP_DEL: begin
        w.addr = REG_DELAY;
        w.data = delay_val;
      end
      OP_DCO:  w.data = TP_DCO;
      OP_FCO:  w.data = TP_FCO;
      OP_RAMP: w.data = TP_RAMP;
      OP_NORM: w.data = TP_NORM;
      default: w.traffic = 1'b0;
    endcase
    return w;
  endfunction

  // Write frame: R/W=0, byte-count=00, 13-bit address, 8-bit data
  function automatic logic [23:0] spi_frame(input logic [12:0] addr, input logic [7:0] data);
    return {3'b000, addr, data};
  endfunction

endpackage

// File: rtl/adc_spi_shifter.sv
// rtl/adc_spi_shifter.sv - 24-bit SPI frame serializer with csb framing and inter-frame gap
module adc_spi_shifter
  import adc_conf_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int CSB_GAP = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [23:0] word,
  output logic        csb,
  output logic        sclk,
  output logic        sdio,
  output logic        in_gap,
  output logic        done
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(CSB_GAP - 1);
  localparam logic [4:0] BIT_LAST = 5'd23;

  sh_phase_e   phase, phase_n;
  logic [7:0]  div_cnt, div_n;
  logic [7:0]  gap_cnt, gap_n;
  logic [4:0]  bit_cnt, bit_n;
  logic [23:0] shreg, shreg_n;
  logic        csb_n, sclk_n, sdio_n, done_n;
  logic        div_wrap;

  // Register the serializer phase, counters and the SPI pins themselves
  always_ff @(posedge clk) begin
    if (rst) begin
      phase   <= SH_IDLE;
      div_cnt <= 8'd0;
      gap_cnt <= 8'd0;
      bit_cnt <= 5'd0;
      shreg   <= 24'd0;
      csb     <= 1'b1;
      sclk    <= 1'b0;
      sdio    <= 1'b0;
      done    <= 1'b0;
    end else begin
      phase   <= phase_n;
      div_cnt <= div_n;
      gap_cnt <= gap_n;
      bit_cnt <= bit_n;
      shreg   <= shreg_n;
      csb     <= csb_n;
      sclk    <= sclk_n;
      sdio    <= sdio_n;
      done    <= done_n;
    end
  end

  // Each bit is CLK_DIV cycles of sclk low (data set up) then CLK_DIV cycles high
  always_comb begin
    phase_n  = phase;
    div_n    = div_cnt;
    gap_n    = gap_cnt;
    bit_n    = bit_cnt;
    shreg_n  = shreg;
    csb_n    = csb;
    sclk_n   = sclk;
    sdio_n   = sdio;
    done_n   = 1'b0;
    div_wrap = (div_cnt == DIV_LAST);
    case (phase)
      SH_IDLE: begin
        if (start) begin
          csb_n   = 1'b0;
          sclk_n  = 1'b0;
          sdio_n  = word[23];
          shreg_n = {word[22:0], 1'b0};
          div_n   = 8'd0;
          bit_n   = 5'd0;
          phase_n = SH_LOW;
        end
      end
      SH_LOW: begin
        div_n = div_cnt + 8'd1;
        if (div_wrap) begin
          div_n   = 8'd0;
          sclk_n  = 1'b1;
          phase_n = SH_HIGH;
        end
      end
      SH_HIGH: begin
        div_n = div_cnt + 8'd1;
        if (div_wrap) begin
          div_n  = 8'd0;
          sclk_n = 1'b0;
          if (bit_cnt == BIT_LAST) begin
            phase_n = SH_TAIL;
          end else begin
            bit_n   = bit_cnt + 5'd1;
            sdio_n  = shreg[23];
            shreg_n = {shreg[22:0], 1'b0};
            phase_n = SH_LOW;
          end
        end
      end
      SH_TAIL: begin
        div_n = div_cnt + 8'd1;
        if (div_wrap) begin
          div_n   = 8'd0;
          csb_n   = 1'b1;
          sdio_n  = 1'b0;
          gap_n   = 8'd0;
          phase_n = SH_GAP;
        end
      end
      SH_GAP: begin
        gap_n = gap_cnt + 8'd1;
        if (gap_cnt == GAP_LAST) begin
          gap_n   = 8'd0;
          done_n  = 1'b1;
          phase_n = SH_IDLE;
        end
      end
      default: phase_n = SH_IDLE;
    endcase
  end

  assign in_gap = (phase == SH_GAP);

endmodule

// File: rtl/adc_spi_conf_engine.sv
// rtl/adc_spi_conf_engine.sv - sequencer/host arbitration and op-to-SPI-write handshake engine
module adc_spi_conf_engine
  import adc_conf_pkg::*;
#(
  parameter int         CLK_DIV   = 4,
  parameter int         CSB_GAP   = 8,
  parameter logic [7:0] DELAY_VAL = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init_ADCconf,
  input  logic [2:0]  op_ADC,
  input  logic        ADC_confrun,
  output logic        end_ADCconf,
  output logic        ADC_confwt,
  input  logic        host_req,
  input  logic [12:0] host_addr,
  input  logic [7:0]  host_data,
  output logic        host_ack,
  output logic        spi_csb,
  output logic        spi_sclk,
  output logic        spi_sdio,
  output logic        busy
);

  conf_state_e state, state_n;
  logic [12:0] cur_addr, cur_addr_n;
  logic [7:0]  cur_data, cur_data_n;
  logic        is_host, is_host_n;
  logic        commit, commit_n;
  logic        pend, pend_n;
  logic [2:0]  pend_op, pend_op_n;
  logic [2:0]  sel_op;
  op_write_t   dec;
  logic        sh_start;
  logic [23:0] sh_word;
  logic        sh_in_gap, sh_done;

  // Register the handshake state and the latched transaction context
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cur_addr <= 13'd0;
      cur_data <= 8'd0;
      is_host  <= 1'b0;
      commit   <= 1'b0;
      pend     <= 1'b0;
      pend_op  <= 3'd0;
    end else begin
      state    <= state_n;
      cur_addr <= cur_addr_n;
      cur_data <= cur_data_n;
      is_host  <= is_host_n;
      commit   <= commit_n;
      pend     <= pend_n;
      pend_op  <= pend_op_n;
    end
  end

  // Arbitrate in IDLE (pending init, then new init, then host) and sequence write + commit
  always_comb begin
    state_n    = state;
    cur_addr_n = cur_addr;
    cur_data_n = cur_data;
    is_host_n  = is_host;
    commit_n   = commit;
    pend_n     = pend;
    pend_op_n  = pend_op;
    sh_start   = 1'b0;
    sh_word    = spi_frame(cur_addr, cur_data);
    sel_op     = pend ? pend_op : op_ADC;
    dec        = decode_op(sel_op, DELAY_VAL);

    // An init arriving while busy is parked; a second one on top of it is dropped
    if (init_ADCconf && (state != ST_IDLE) && !pend) begin
      pend_n    = 1'b1;
      pend_op_n = op_ADC;
    end

    case (state)
      ST_IDLE: begin
        if (pend || init_ADCconf) begin
          pend_n     = 1'b0;
          is_host_n  = 1'b0;
          cur_addr_n = dec.addr;
          cur_data_n = dec.data;
          state_n    = dec.traffic ? ST_LOAD : ST_DONE;
        end else if (host_req && !ADC_confrun) begin
          is_host_n  = 1'b1;
          cur_addr_n = host_addr;
          cur_data_n = host_data;
          state_n    = ST_LOAD;
        end
      end
      ST_LOAD: begin
        sh_start = 1'b1;
        commit_n = 1'b0;
        state_n  = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (sh_in_gap) state_n = ST_GAP;
      end
      ST_GAP: begin
        if (sh_done) state_n = commit ? ST_DONE : ST_COMMIT_LOAD;
      end
      ST_COMMIT_LOAD: begin
        sh_start = 1'b1;
        sh_word  = spi_frame(REG_XFER, XFER_COMMIT);
        commit_n = 1'b1;
        state_n  = ST_SHIFT;
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  adc_spi_shifter #(
    .CLK_DIV (CLK_DIV),
    .CSB_GAP (CSB_GAP)
  ) u_shifter (
    .clk    (clk),
    .rst    (rst),
    .start  (sh_start),
    .word   (sh_word),
    .csb    (spi_csb),
    .sclk   (spi_sclk),
    .sdio   (spi_sdio),
    .in_gap (sh_in_gap),
    .done   (sh_done)
  );

  assign end_ADCconf = (state == ST_DONE) && !is_host;
  assign host_ack    = (state == ST_DONE) && is_host;
  assign ADC_confwt  = is_host && ((state == ST_LOAD) || (state == ST_SHIFT) ||
                                   (state == ST_GAP)  || (state == ST_COMMIT_LOAD));
  assign busy        = (state != ST_IDLE) || pend;

endmodule
